// File: rtl/vga_sync_module.sv
// VGA sync timing generator: free-running horizontal/vertical counters with
// registered sync, display-ready and pixel-address outputs.
module vga_sync_module #(
  parameter int unsigned H_VISIBLE   = 800,
  parameter int unsigned H_FRONT     = 56,
  parameter int unsigned H_SYNC      = 120,
  parameter int unsigned H_BACK      = 64,
  parameter int unsigned V_VISIBLE   = 600,
  parameter int unsigned V_FRONT     = 37,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BACK      = 23,
  parameter logic        SYNC_ACTIVE = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Ready_Sig,
  output logic [10:0] Column_Addr_Sig,
  output logic [10:0] Row_Addr_Sig,
  output logic        Frame_Start_Sig
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEGIN = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_BEGIN = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             ready_c;
  logic             hsync_c;
  logic             vsync_c;
  logic             frame_start_c;

  // Pixel/line counters; row advances only when the column wraps.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Region decode of the current counter position.
  always_comb begin
    ready_c       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_c       = (h_cnt >= H_SYNC_BEGIN) && (h_cnt < H_SYNC_END);
    vsync_c       = (v_cnt >= V_SYNC_BEGIN) && (v_cnt < V_SYNC_END);
    frame_start_c = (h_cnt == '0) && (v_cnt == '0);
  end

  // Registered outputs, one clock behind the counters; addresses zeroed in blanking.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      HSYNC_Sig       <= ~SYNC_ACTIVE;
      VSYNC_Sig       <= ~SYNC_ACTIVE;
      Ready_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Frame_Start_Sig <= 1'b0;
    end else begin
      HSYNC_Sig       <= hsync_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      VSYNC_Sig       <= vsync_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      Ready_Sig       <= ready_c;
      Column_Addr_Sig <= ready_c ? h_cnt : '0;
      Row_Addr_Sig    <= ready_c ? v_cnt : '0;
      Frame_Start_Sig <= frame_start_c;
    end
  end

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench for vga_sync_module: default timing for line-level checks,
// a medium and a tiny timing set for frame-level checks within a short run.
module tb_vga_sync_module;

  logic        CLK;
  logic        RSTn;

  logic        d_hs, d_vs, d_rdy, d_fs;
  logic [10:0] d_col, d_row;
  logic        m_hs, m_vs, m_rdy, m_fs;
  logic [10:0] m_col, m_row;
  logic        s_hs, s_vs, s_rdy, s_fs;
  logic [10:0] s_col, s_row;

  int total;
  int bad;

  int d_hs_n, d_hs_first, d_hs_last, d_rdy_n, d_vs_n, d_fs_n;
  int m_fs_n, m_rdy1_n, m_rdy2_n, m_blank_rdy, m_vs_n, m_vs_first, m_vs_last;
  int s_hs_low, s_vs_low, s_vs_first, s_vs_last, s_rdy_n, s_fs_n;
  int viol;

  // Default timing: 1040 x 666.
  vga_sync_module u_def (
    .CLK(CLK), .RSTn(RSTn),
    .HSYNC_Sig(d_hs), .VSYNC_Sig(d_vs), .Ready_Sig(d_rdy),
    .Column_Addr_Sig(d_col), .Row_Addr_Sig(d_row), .Frame_Start_Sig(d_fs)
  );

  // Medium timing: H 40/4/8/4 = 56, V 30/3/2/2 = 37, frame 2072.
  vga_sync_module #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b1)
  ) u_med (
    .CLK(CLK), .RSTn(RSTn),
    .HSYNC_Sig(m_hs), .VSYNC_Sig(m_vs), .Ready_Sig(m_rdy),
    .Column_Addr_Sig(m_col), .Row_Addr_Sig(m_row), .Frame_Start_Sig(m_fs)
  );

  // Tiny timing, negative sync: H 4/1/2/1 = 8, V 3/1/1/1 = 6, frame 48.
  vga_sync_module #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) u_small (
    .CLK(CLK), .RSTn(RSTn),
    .HSYNC_Sig(s_hs), .VSYNC_Sig(s_vs), .Ready_Sig(s_rdy),
    .Column_Addr_Sig(s_col), .Row_Addr_Sig(s_row), .Frame_Start_Sig(s_fs)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_all(input string tag);
    chk({tag, "_d_hs"}, d_hs, 0);   chk({tag, "_d_vs"}, d_vs, 0);
    chk({tag, "_d_rdy"}, d_rdy, 0); chk({tag, "_d_col"}, d_col, 0);
    chk({tag, "_d_row"}, d_row, 0); chk({tag, "_d_fs"}, d_fs, 0);
    chk({tag, "_m_hs"}, m_hs, 0);   chk({tag, "_m_rdy"}, m_rdy, 0);
    chk({tag, "_m_col"}, m_col, 0); chk({tag, "_m_row"}, m_row, 0);
    chk({tag, "_m_fs"}, m_fs, 0);
    chk({tag, "_s_hs"}, s_hs, 1);   chk({tag, "_s_vs"}, s_vs, 1);
    chk({tag, "_s_rdy"}, s_rdy, 0);
  endtask

  initial begin
    CLK = 1'b0; RSTn = 1'b0;
    total = 0; bad = 0; viol = 0;
    d_hs_n = 0; d_hs_first = 0; d_hs_last = 0; d_rdy_n = 0; d_vs_n = 0; d_fs_n = 0;
    m_fs_n = 0; m_rdy1_n = 0; m_rdy2_n = 0; m_blank_rdy = 0;
    m_vs_n = 0; m_vs_first = 0; m_vs_last = 0;
    s_hs_low = 0; s_vs_low = 0; s_vs_first = 0; s_vs_last = 0; s_rdy_n = 0; s_fs_n = 0;

    // Reset held for three edges.
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_all("rst");

    @(negedge CLK);
    RSTn = 1'b1;

    // Edge e (from release): outputs describe linear position e-1.
    for (int e = 1; e <= 4145; e++) begin
      @(posedge CLK);
      #1;

      if (e == 1) begin
        chk("d_e1_rdy", d_rdy, 1); chk("d_e1_col", d_col, 0);
        chk("d_e1_row", d_row, 0); chk("d_e1_fs", d_fs, 1);
      end
      if (e == 2) begin
        chk("d_e2_fs", d_fs, 0); chk("d_e2_col", d_col, 1);
      end
      if (e == 800) begin
        chk("d_e800_col", d_col, 799); chk("d_e800_rdy", d_rdy, 1);
      end
      if (e == 801) begin
        chk("d_e801_rdy", d_rdy, 0); chk("d_e801_col", d_col, 0);
        chk("d_e801_row", d_row, 0);
      end
      if (e == 1041) begin
        chk("d_e1041_col", d_col, 0); chk("d_e1041_row", d_row, 1);
        chk("d_e1041_rdy", d_rdy, 1);
      end
      if (e <= 1040) begin
        if (d_hs) begin
          d_hs_n++;
          if (d_hs_first == 0) d_hs_first = e;
          d_hs_last = e;
        end
        if (d_rdy) d_rdy_n++;
      end
      if (d_vs) d_vs_n++;
      if (d_fs) d_fs_n++;

      if (e == 1625) begin
        chk("m_row29", m_row, 29); chk("m_row29_rdy", m_rdy, 1);
        chk("m_row29_col", m_col, 0);
      end
      if (e == 2073) chk("m_fs_2073", m_fs, 1);
      if (e == 4145) chk("m_fs_4145", m_fs, 1);
      if (m_fs) m_fs_n++;
      if (e <= 2072) begin
        if (m_rdy) m_rdy1_n++;
        if (e >= 1681 && m_rdy) m_blank_rdy++;
        if (m_vs) begin
          m_vs_n++;
          if (m_vs_first == 0) m_vs_first = e;
          m_vs_last = e;
        end
      end else if (e <= 4144) begin
        if (m_rdy) m_rdy2_n++;
      end

      if (e <= 48) begin
        if (!s_hs) s_hs_low++;
        if (!s_vs) begin
          s_vs_low++;
          if (s_vs_first == 0) s_vs_first = e;
          s_vs_last = e;
        end
        if (s_rdy) s_rdy_n++;
      end
      if (s_fs) s_fs_n++;

      if (!d_rdy && (d_col != 0 || d_row != 0)) viol++;
      if (!m_rdy && (m_col != 0 || m_row != 0)) viol++;
      if (!s_rdy && (s_col != 0 || s_row != 0)) viol++;
    end

    chk("d_hs_count", d_hs_n, 120);
    chk("d_hs_first", d_hs_first, 857);
    chk("d_hs_last", d_hs_last, 976);
    chk("d_rdy_line0", d_rdy_n, 800);
    chk("d_vs_never", d_vs_n, 0);
    chk("d_fs_count", d_fs_n, 1);
    chk("m_fs_count", m_fs_n, 3);
    chk("m_rdy_frame1", m_rdy1_n, 1200);
    chk("m_rdy_frame2", m_rdy2_n, 1200);
    chk("m_blank_rdy", m_blank_rdy, 0);
    chk("m_vs_count", m_vs_n, 112);
    chk("m_vs_first", m_vs_first, 1849);
    chk("m_vs_last", m_vs_last, 1960);
    chk("s_hs_low", s_hs_low, 12);
    chk("s_vs_low", s_vs_low, 8);
    chk("s_vs_first", s_vs_first, 33);
    chk("s_vs_last", s_vs_last, 40);
    chk("s_rdy_count", s_rdy_n, 12);
    chk("s_fs_count", s_fs_n, 87);
    chk("blank_addr_viol", viol, 0);

    // Advance the medium instance to row 15, column 20 of its third frame.
    for (int e = 4146; e <= 5005; e++) @(posedge CLK);
    #1;
    chk("m_pre_rst_row", m_row, 15);
    chk("m_pre_rst_col", m_col, 20);
    chk("m_pre_rst_rdy", m_rdy, 1);

    // Single-edge mid-frame reset.
    @(negedge CLK);
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    chk_reset_all("mid_rst");

    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_m_col", m_col, 0); chk("post_m_row", m_row, 0);
    chk("post_m_rdy", m_rdy, 1); chk("post_m_fs", m_fs, 1);
    chk("post_d_rdy", d_rdy, 1); chk("post_d_fs", d_fs, 1);
    chk("post_s_fs", s_fs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
